fir_bist_sequencer: RTL and testbench
=====================================

// Module: fir_bist_sequencer
// PURPOSE
//  On-chip stimulus driver and checker for the FIR filter pair (fir_original / fir_retimed).
//  - Generates the directed input sequence: impulse, step, alternating, flush.
//  - Drives the shared data/ena inputs of both filters.
//  - Aligns the original output to the retimed output by delaying it LAT_DIFF samples.
//  - Compares the two outputs and reports error count and pass/fail.
//  - Placed beside the two FIR instances so regression runs in silicon and in the FPGA build.
// PARAMETERS
//  N_TAPS      4    filter taps; sets phase lengths and warm-up
//  DATA_WIDTH  18   stimulus sample width (signed)
//  COEFF_WIDTH 18   coefficient width; used only to size OUT_W
//  LAT_DIFF    3    extra pipeline latency of the retimed filter, in enabled samples
//  ALT_LEN     10   number of samples in the alternating phase
//  ERR_W       16   width of the error counter
//  OUT_W is derived, not a parameter: OUT_W = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS).
// PORTS
//  clk           in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  start         in   1           single-cycle pulse that starts a run
//  ena           out  1           enable to both FIRs
//  data_out      out  DATA_WIDTH  stimulus to the data_in port of both FIRs
//  orig_in       in   OUT_W       data_out of fir_original
//  retimed_in    in   OUT_W       data_out of fir_retimed
//  busy          out  1           run in progress
//  done          out  1           run finished; held until the next accepted start
//  pass          out  1           done && err_count == 0
//  err_count     out  ERR_W       number of mismatches, saturating
//  first_err_idx out  16          sample index of the first mismatch; 0xFFFF if none
// BEHAVIOUR
//  Reset and timing
//  - Reset values: every output 0, except first_err_idx = 0xFFFF. State is IDLE.
//  - Reset asserted mid-run aborts immediately. No partial result is kept.
//  - ena and data_out are registered. Both FIRs sample data_out on every edge where ena = 1.
//  - sample_idx counts edges with ena = 1 and is cleared on an accepted start.
//  FSM: IDLE -> IMPULSE -> STEP -> ALT -> [RAND] -> FLUSH -> DONE
//  - IDLE: start = 1 clears err_count, first_err_idx, sample_idx and the delay line, then enters IMPULSE.
//  - IMPULSE (N_TAPS+3 samples): value 1, then zeros.
//  - STEP (N_TAPS+3 samples): constant +10.
//  - ALT (ALT_LEN samples): +5, -5, +5, ... The first sample is +5.
//  - FLUSH (N_TAPS+5+LAT_DIFF samples): zeros.
//  - DONE: ena = 0, data_out = 0, done = 1. start = 1 restarts the run exactly as from IDLE.
//  - busy = 1 in every state except IDLE and DONE. start while busy is ignored.
//  - Phase transitions have no gap: ena stays high across phase boundaries.
//  Alignment and compare
//  - orig_in feeds a LAT_DIFF-deep delay line that shifts only when ena = 1.
//  - Compare happens on each edge with ena = 1 and sample_idx >= N_TAPS+LAT_DIFF+2 (warm-up).
//  - The compared values are retimed_in and the delay-line tail before the shift.
//  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
//  - On the first mismatch of a run: first_err_idx <= sample_idx.
//  - Comparison is bitwise, so X/Z on either input counts as a mismatch in simulation.
//  - pass is combinational from done and err_count.
// CONFIGURATION
//  - FIR_BIST_LFSR_EN defined:
//    - Adds a RAND phase of 64 samples between ALT and FLUSH.
//    - Source is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 reloaded on each start.
//    - data_out is the sign-extended low DATA_WIDTH bits of the LFSR state, advanced once per sample.
//  - FIR_BIST_LFSR_EN undefined: no RAND phase and no LFSR logic. ALT goes directly to FLUSH.
// STRUCTURE
//  - fir_pkg (shared):
//    - output-width function: DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS)
//    - bist_state_t enum
//    - stimulus constants IMPULSE_VAL=1, STEP_VAL=10, ALT_VAL=5
//    - LFSR seed and taps
//  - Sub-module fir_bist_delay: parameterised width/depth shift register with enable and async clear.
//    It aligns orig_in.
//  - Top level holds the FSM, phase and sample counters, stimulus mux and checker.
// TESTING (N_TAPS=4, LAT_DIFF=3, ALT_LEN=10, macro off unless stated)
//  1. Matched fir_original + fir_retimed, one start pulse
//     -> 36 enabled samples (7+7+10+12), then done=1, pass=1, err_count=0, first_err_idx=0xFFFF.
//  2. Bench flips retimed_in bit 0 on sample 20 only
//     -> err_count=1, first_err_idx=20, pass=0 at done.
//  3. reset_n pulsed low at sample 15
//     -> outputs zero in the same cycle, first_err_idx=0xFFFF, state IDLE.
//     -> A new start then completes the full 36 samples with pass=1.
//  4. start pulsed at sample 10 (ignored, run length still 36); start pulsed in DONE
//     -> err_count cleared, second run identical to the first.
//  5. retimed_in tied to constant 1, ERR_W=4
//     -> err_count saturates at 15 and does not wrap; pass=0.
//  6. FIR_BIST_LFSR_EN defined, matched DUTs
//     -> 100 samples, first RAND sample = sign-extended low 18 bits of 0xACE1, pass=1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR BIST sequencer.
//   - out_width(): FIR output width from data width, coefficient width and tap count
//   - bist_state_t: sequencer FSM states
//   - stimulus constants and the LFSR seed/tap mask
package fir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StImpulse,
        StStep,
        StAlt,
        StRand,
        StFlush,
        StDone
    } bist_state_t;

    localparam int IMPULSE_VAL = 1;
    localparam int STEP_VAL    = 10;
    localparam int ALT_VAL     = 5;

    localparam int unsigned RAND_LEN  = 64;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned out_width(input int unsigned data_w,
                                              input int unsigned coeff_w,
                                              input int unsigned n_taps);
        return data_w + coeff_w + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_bist_delay.sv
// Enabled shift register used to align the original FIR output to the retimed one.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low clear
//   clr      in   synchronous clear of all stages (wins over en)
//   en       in   shift enable
//   din      in   WIDTH  value shifted into stage 0
//   dout     out  WIDTH  tail stage (din delayed by DEPTH enabled shifts)
// DEPTH must be at least 1.
module fir_bist_delay #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_bist_sequencer.sv
// Stimulus driver and checker for the fir_original / fir_retimed pair.
// Plays impulse, step, alternating, [random], flush samples into both filters, delays the
// original output by LAT_DIFF enabled samples and compares it against the retimed output.
// Optional feature macro: FIR_BIST_LFSR_EN adds a 64-sample LFSR phase between ALT and FLUSH.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          pulse; accepted only in idle or done
//   ena, data_out  registered enable and stimulus sample to both filters
//   orig_in        data_out of fir_original
//   retimed_in     data_out of fir_retimed
//   busy, done     run in progress / run finished (held until next accepted start)
//   pass           done with zero mismatches
//   err_count      saturating mismatch count
//   first_err_idx  sample index of first mismatch, 0xFFFF if none
module fir_bist_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned N_TAPS      = 4,
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned COEFF_WIDTH = 18,
    parameter int unsigned LAT_DIFF    = 3,
    parameter int unsigned ALT_LEN     = 10,
    parameter int unsigned ERR_W       = 16,
    localparam int unsigned OUT_W      = out_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  ena,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [OUT_W-1:0]      orig_in,
    input  logic [OUT_W-1:0]      retimed_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [15:0]           first_err_idx
);

    localparam logic [DATA_WIDTH-1:0] IMP_D   = DATA_WIDTH'(IMPULSE_VAL);
    localparam logic [DATA_WIDTH-1:0] STEP_D  = DATA_WIDTH'(STEP_VAL);
    localparam logic [DATA_WIDTH-1:0] ALT_P_D = DATA_WIDTH'(ALT_VAL);
    localparam logic [DATA_WIDTH-1:0] ALT_N_D = DATA_WIDTH'(-ALT_VAL);
    localparam logic [15:0]           WARM_UP = 16'(N_TAPS + LAT_DIFF + 2);

    bist_state_t           state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           phase_len;
    logic                  phase_last;
    logic                  ena_q, ena_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [15:0]           first_q, first_d;
    logic [15:0]           idx_q, idx_d;
    logic                  start_acc;
    logic [OUT_W-1:0]      orig_dly;
    logic                  mismatch;

`ifdef FIR_BIST_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    always_comb begin
        phase_len = 16'd1;
        case (state_q)
            StImpulse, StStep: phase_len = 16'(N_TAPS + 3);
            StAlt:             phase_len = 16'(ALT_LEN);
            StRand:            phase_len = 16'(RAND_LEN);
            StFlush:           phase_len = 16'(N_TAPS + 5 + LAT_DIFF);
            default:           phase_len = 16'd1;
        endcase
    end

    assign phase_last = (cnt_q == phase_len - 16'd1);

    // Each running state emits one sample per cycle; ena/data are registered from here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ena_d     = 1'b0;
        data_d    = '0;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = StImpulse;
                    cnt_d     = '0;
                end
            end
            StImpulse: begin
                ena_d   = 1'b1;
                data_d  = (cnt_q == 16'd0) ? IMP_D : '0;
                cnt_d   = phase_last ? 16'd0 : cnt_q + 16'd1;
                state_d = phase_last ? StStep : StImpulse;
            end
            StStep: begin
                ena_d   = 1'b1;
                data_d  = STEP_D;
                cnt_d   = phase_last ? 16'd0 : cnt_q + 16'd1;
                state_d = phase_last ? StAlt : StStep;
            end
            StAlt: begin
                ena_d   = 1'b1;
                data_d  = cnt_q[0] ? ALT_N_D : ALT_P_D;
                cnt_d   = phase_last ? 16'd0 : cnt_q + 16'd1;
`ifdef FIR_BIST_LFSR_EN
                state_d = phase_last ? StRand : StAlt;
`else
                state_d = phase_last ? StFlush : StAlt;
`endif
            end
`ifdef FIR_BIST_LFSR_EN
            StRand: begin
                ena_d   = 1'b1;
                data_d  = DATA_WIDTH'($signed(lfsr_q));
                cnt_d   = phase_last ? 16'd0 : cnt_q + 16'd1;
                state_d = phase_last ? StFlush : StRand;
            end
`endif
            StFlush: begin
                ena_d   = 1'b1;
                cnt_d   = phase_last ? 16'd0 : cnt_q + 16'd1;
                state_d = phase_last ? StDone : StFlush;
            end
            default: state_d = StIdle;
        endcase
        // busy covers the accept cycle through the cycle of the last enabled sample
        busy_d = ((state_d != StIdle) && (state_d != StDone)) || ena_d;
        done_d = (state_q == StDone) && !start_acc;
    end

`ifdef FIR_BIST_LFSR_EN
    always_comb begin
        lfsr_d = lfsr_q;
        if (start_acc) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == StRand) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end
`endif

    fir_bist_delay #(
        .WIDTH (OUT_W),
        .DEPTH (LAT_DIFF)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_acc),
        .en      (ena_q),
        .din     (orig_in),
        .dout    (orig_dly)
    );

    // Case inequality so that X/Z on either side is flagged in simulation.
    assign mismatch = (retimed_in !== orig_dly);

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        idx_d   = idx_q;
        if (start_acc) begin
            err_d   = '0;
            first_d = 16'hFFFF;
            idx_d   = '0;
        end else if (ena_q) begin
            idx_d = idx_q + 16'd1;
            if ((idx_q >= WARM_UP) && mismatch) begin
                if (err_q == '0) first_d = idx_q;
                if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            first_q <= 16'hFFFF;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            first_q <= first_d;
            idx_q   <= idx_d;
        end
    end

    assign ena           = ena_q;
    assign data_out      = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_fir_bist_sequencer.sv
module tb_fir_bist_sequencer;

    localparam int N_TAPS  = 4;
    localparam int DW      = 18;
    localparam int CW      = 18;
    localparam int LAT     = 3;
    localparam int ALT_LEN = 10;
    localparam int OW      = DW + CW + $clog2(N_TAPS);
    localparam int WARM    = N_TAPS + LAT + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [OW-1:0] orig_in;
    logic [OW-1:0] retimed_in;
    wire  [OW-1:0] one_in = OW'(1);

    logic          ena, busy, done, pass;
    logic [DW-1:0] data_out;
    logic [15:0]   err_count, first_err_idx;

    logic          ena2, busy2, done2, pass2;
    logic [DW-1:0] data_out2;
    logic [3:0]    err_count2;
    logic [15:0]   first_err_idx2;

    int total = 0;
    int bad   = 0;

    longint        coef [N_TAPS];
    longint        hist [N_TAPS];
    logic [OW-1:0] rpipe[$];
    logic [OW-1:0] ret_model;
    logic [DW-1:0] exp_seq[$];
    logic [DW-1:0] sampq[$];
    logic [OW-1:0] origq[$];
    logic [OW-1:0] retq[$];
    logic [127:0]  fault;

    always #5 clk = ~clk;

    fir_bist_sequencer #(
        .N_TAPS(N_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .LAT_DIFF(LAT),
        .ALT_LEN(ALT_LEN), .ERR_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ena(ena), .data_out(data_out),
        .orig_in(orig_in), .retimed_in(retimed_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    // Narrow error counter against a retimed input stuck at 1: exercises saturation.
    fir_bist_sequencer #(
        .N_TAPS(N_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .LAT_DIFF(LAT),
        .ALT_LEN(ALT_LEN), .ERR_W(4)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .ena(ena2), .data_out(data_out2),
        .orig_in(orig_in), .retimed_in(one_in), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_err_idx(first_err_idx2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: record what both filters sample on this edge, then advance the filter models.
    task automatic tick();
        logic          pe;
        logic [DW-1:0] pd;
        logic [OW-1:0] po, pr;
        pe = ena; pd = data_out; po = orig_in; pr = retimed_in;
        @(posedge clk);
        if (pe) begin
            longint acc;
            sampq.push_back(pd); origq.push_back(po); retq.push_back(pr);
            for (int j = N_TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = longint'($signed(pd));
            acc = 0;
            for (int j = 0; j < N_TAPS; j++) acc += coef[j] * hist[j];
            rpipe.push_back(OW'(acc));
            if (rpipe.size() > LAT + 1) void'(rpipe.pop_front());
        end
        #1;
        orig_in    = (rpipe.size() > 0) ? rpipe[rpipe.size()-1] : '0;
        ret_model  = (rpipe.size() == LAT + 1) ? rpipe[0] : '0;
        retimed_in = ret_model ^ OW'(fault[sampq.size()]);
    endtask

    // Retimed sample k must equal the original sample k-LAT once past warm-up.
    task automatic score(input bit use_one, output int n, output int first);
        logic [OW-1:0] r;
        n = 0; first = 'hFFFF;
        for (int k = WARM; k < sampq.size(); k++) begin
            r = use_one ? OW'(1) : retq[k];
            if (r !== origq[k-LAT]) begin
                if (n == 0) first = k;
                n++;
            end
        end
    endtask

    task automatic check_idle_vals(input string tag);
        chk({tag, "_ena"},   ena, 0);
        chk({tag, "_data"},  data_out, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_pass"},  pass, 0);
        chk({tag, "_err"},   err_count, 0);
        chk({tag, "_first"}, first_err_idx, 16'hFFFF);
        chk({tag, "_err2"},  err_count2, 0);
    endtask

    task automatic start_run(input string tag);
        sampq.delete(); origq.delete(); retq.delete();
        repeat ($urandom_range(0, 3)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_on"},   busy, 1);
        chk({tag, "_done_clr"},  done, 0);
        chk({tag, "_err_clr"},   err_count, 0);
        chk({tag, "_first_clr"}, first_err_idx, 16'hFFFF);
    endtask

    task automatic wait_samples(input string tag, input int n);
        int lim = 0;
        while (sampq.size() < n && lim < 200) begin tick(); lim++; end
        chk({tag, "_reach"}, 64'(sampq.size()), 64'(n));
    endtask

    task automatic finish_run(input string tag);
        int lim, n, first, n2, first2;
        lim = 0;
        while (done !== 1'b1 && lim < 400) begin tick(); lim++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_nsamp"}, 64'(sampq.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < sampq.size(); i++)
            chk($sformatf("%s_stim%0d", tag, i), sampq[i], exp_seq[i]);
        score(1'b0, n, first);
        score(1'b1, n2, first2);
        chk({tag, "_err"},    err_count, 64'((n > 65535) ? 65535 : n));
        chk({tag, "_first"},  first_err_idx, 64'(first));
        chk({tag, "_pass"},   pass, 64'(n == 0));
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_ena"},    ena, 0);
        chk({tag, "_done2"},  done2, 1);
        chk({tag, "_err2"},   err_count2, 64'((n2 > 15) ? 15 : n2));
        chk({tag, "_first2"}, first_err_idx2, 64'(first2));
        chk({tag, "_pass2"},  pass2, 64'(n2 == 0));
    endtask

    initial begin
        logic signed [DW-1:0] v;
        logic [15:0]          s;

        reset_n = 1'b0; start = 1'b0; orig_in = '0; retimed_in = '0; ret_model = '0;
        fault = '0;
        for (int j = 0; j < N_TAPS; j++) begin
            coef[j] = longint'($urandom_range(0, 200)) - 100;
            hist[j] = 0;
        end

        // Expected stimulus from the phase rules.
        for (int i = 0; i < N_TAPS + 3; i++) exp_seq.push_back((i == 0) ? DW'(1) : DW'(0));
        for (int i = 0; i < N_TAPS + 3; i++) exp_seq.push_back(DW'(10));
        for (int i = 0; i < ALT_LEN; i++) exp_seq.push_back((i % 2 == 0) ? DW'(5) : DW'(-5));
`ifdef FIR_BIST_LFSR_EN
        s = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
            v = $signed(s);
            exp_seq.push_back(v);
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
`endif
        for (int i = 0; i < N_TAPS + 5 + LAT; i++) exp_seq.push_back(DW'(0));

        repeat (3) @(negedge clk);
        check_idle_vals("rst");
        reset_n = 1'b1;
        tick();
        check_idle_vals("idle");

        // Matched filters.
        start_run("t1");
        finish_run("t1");

        // Single corrupted retimed sample.
        fault = '0; fault[20] = 1'b1;
        start_run("t2");
        finish_run("t2");
        chk("t2_err_exact",   err_count, 1);
        chk("t2_first_exact", first_err_idx, 20);
        fault = '0;

        // Restart from done after a failing run; extra start mid-run must be ignored.
        start_run("t4");
        wait_samples("t4", 10);
        start = 1'b1; tick(); start = 1'b0;
        finish_run("t4");

        // Random corruption positions, some possibly inside warm-up.
        fault = '0;
        for (int i = 0; i < 3; i++) fault[$urandom_range(0, 35)] = 1'b1;
        start_run("tr");
        finish_run("tr");
        fault = '0;

        // Asynchronous abort mid-run, then a clean run.
        start_run("t3a");
        wait_samples("t3a", 15);
        #2 reset_n = 1'b0;
        #1 check_idle_vals("t3_abort");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_idle_vals("t3_idle");
        start_run("t3b");
        finish_run("t3b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
